// File: rtl/taus_urng.sv
// Combined three-component Tausworthe (taus88) uniform generator with seed
// sanitisation, post-seed warm-up and an enable-gated registered output.

module taus_urng_chk #(
  parameter logic [31:0] SEED1  = 32'h12345678,
  parameter logic [31:0] SEED2  = 32'h9ABCDEF0,
  parameter logic [31:0] SEED3  = 32'h0F1E2D3C,
  parameter int          WARMUP = 16
) ();

  // A fallback seed that is itself illegal would lock a component at zero.
  if (SEED1[31:1] == 31'd0) begin : g_bad_seed1
    $error("taus_urng: SEED1 must have a nonzero bit in [31:1]");
  end
  if (SEED2[31:3] == 29'd0) begin : g_bad_seed2
    $error("taus_urng: SEED2 must have a nonzero bit in [31:3]");
  end
  if (SEED3[31:4] == 28'd0) begin : g_bad_seed3
    $error("taus_urng: SEED3 must have a nonzero bit in [31:4]");
  end
  if ((WARMUP < 0) || (WARMUP > 255)) begin : g_bad_warmup
    $error("taus_urng: WARMUP must be within 0..255");
  end

endmodule

module taus_urng #(
  parameter logic [31:0] SEED1  = 32'h12345678,
  parameter logic [31:0] SEED2  = 32'h9ABCDEF0,
  parameter logic [31:0] SEED3  = 32'h0F1E2D3C,
  parameter int          WARMUP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [95:0] seed_in,
  input  logic        en,
  output logic [31:0] out_32,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam logic [7:0] WARMUP_C   = 8'(WARMUP);
  localparam state_t     ST_RESTART = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  taus_urng_chk #(
    .SEED1  (SEED1),
    .SEED2  (SEED2),
    .SEED3  (SEED3),
    .WARMUP (WARMUP)
  ) u_chk ();

  function automatic logic [95:0] taus_step(input logic [95:0] s);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = s[95:64];
    b = s[63:32];
    c = s[31:0];
    taus_step = {((a & 32'hFFFFFFFE) << 5'd12) ^ (((a << 5'd13) ^ a) >> 5'd19),
                 ((b & 32'hFFFFFFF8) << 5'd4)  ^ (((b << 5'd2)  ^ b) >> 5'd25),
                 ((c & 32'hFFFFFFF0) << 5'd17) ^ (((c << 5'd3)  ^ c) >> 5'd11)};
  endfunction

  // Each component whose significant bits are all zero falls back to its parameter.
  function automatic logic [95:0] sanitise(input logic [95:0] s);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    a = (s[95:65] != 31'd0) ? s[95:64] : SEED1;
    b = (s[63:35] != 29'd0) ? s[63:32] : SEED2;
    c = (s[31:4]  != 28'd0) ? s[31:0]  : SEED3;
    sanitise = {a, b, c};
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [95:0] taus_r;
  logic [95:0] taus_s;
  logic [95:0] step_s;
  logic [31:0] sample_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_s;
  logic [31:0] out_r;
  logic [31:0] out_s;
  logic        valid_r;
  logic        valid_s;

  assign step_s   = taus_step(taus_r);
  assign sample_s = step_s[95:64] ^ step_s[63:32] ^ step_s[31:0];

  // Next-state logic: seed load wins, warm-up free-runs, run steps on en.
  always_comb begin
    state_s = state_r;
    taus_s  = taus_r;
    cnt_s   = cnt_r;
    out_s   = out_r;
    valid_s = 1'b0;
    if (seed_load) begin
      taus_s  = sanitise(seed_in);
      cnt_s   = WARMUP_C;
      out_s   = 32'd0;
      state_s = ST_RESTART;
    end else begin
      case (state_r)
        ST_WARMUP: begin
          taus_s = step_s;
          if (cnt_r <= 8'd1) begin
            cnt_s   = 8'd0;
            state_s = ST_RUN;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end
        ST_RUN: begin
          if (en) begin
            taus_s  = step_s;
            out_s   = sample_s;
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
        end
        default: begin
          state_s = ST_RUN;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RESTART;
      taus_r  <= {SEED1, SEED2, SEED3};
      cnt_r   <= WARMUP_C;
      out_r   <= 32'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      taus_r  <= taus_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      valid_r <= valid_s;
    end
  end

  assign out_32 = out_r;
  assign valid  = valid_r;
  assign busy   = (state_r == ST_WARMUP);

endmodule

// File: doc/taus_urng.md
Name: taus_urng

Overview:
- 32-bit uniform random number generator: a three-component combined Tausworthe (taus88) generator.
- Sits directly upstream of the hat shaping pipeline and supplies its 32-bit uniform input word.
- Supports runtime seed loading with seed sanitisation and a post-seed warm-up period.
- Supports output stalling via an enable, so the multihat chain can be paused.

Parameters:
SEED1, 32'h12345678, component-1 state after reset; also the fallback for an illegal s1 seed
SEED2, 32'h9ABCDEF0, component-2 state after reset; also the fallback for an illegal s2 seed
SEED3, 32'h0F1E2D3C, component-3 state after reset; also the fallback for an illegal s3 seed
WARMUP, 16, number of discarded generator steps after reset or seed load (0..255)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
seed_load  input  1  load seed_in this cycle; has priority over en
seed_in  input  96  {s1[95:64], s2[63:32], s3[31:0]}
en  input  1  request one new sample (honoured in RUN only)
out_32  output  32  registered random word, feeds the hat stage's 32-bit input
valid  output  1  one-cycle pulse: out_32 updated this cycle
busy  output  1  high while in WARMUP

Behaviour:
- Step function on state (s1, s2, s3), all 32-bit, with shifts truncated to 32 bits:
  - s1' = ((s1 & FFFFFFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19)
  - s2' = ((s2 & FFFFFFF8) << 4) ^ (((s2 << 2) ^ s2) >> 25)
  - s3' = ((s3 & FFFFFFF0) << 17) ^ (((s3 << 3) ^ s3) >> 11)
  - sample = s1' ^ s2' ^ s3'
- Seed legality:
  - Rules: s1[31:1] != 0, s2[31:3] != 0, s3[31:4] != 0.
  - Each illegal component is independently replaced by its SEED parameter; legal components load unchanged.
  - Parameter defaults must be legal; add an elaboration-time check.
- FSM states: WARMUP, RUN.
- Reset (asynchronous):
  - s1/s2/s3 <= SEED1/2/3; warm-up counter <= WARMUP.
  - out_32 <= 0, valid <= 0.
  - State <= WARMUP if WARMUP > 0, else RUN.
  - busy = 1 iff WARMUP > 0.
- WARMUP:
  - State steps every cycle regardless of en; out_32 holds; valid = 0.
  - Counter decrements each step; after the step that makes it 0, go to RUN.
  - Exactly WARMUP steps are discarded.
- RUN:
  - en = 1: state steps; out_32 <= sample registered on the same edge; valid = 1 the following cycle.
  - Latency from en asserted to valid is 1 cycle; back-to-back en gives one sample per cycle.
  - en = 0: state and out_32 hold; valid = 0.
- seed_load = 1 in any state:
  - Sanitised seed is written to the state; counter <= WARMUP; out_32 <= 0; valid <= 0.
  - en is ignored that cycle.
  - Next state is WARMUP (RUN if WARMUP = 0).
  - A load during WARMUP restarts the full warm-up.
- busy = (state == WARMUP), combinational from the state register.
- The generator never reaches all-zero states: the legality rules guarantee the period.
- Reset mid-operation: all registers return to reset values immediately; any in-flight valid is dropped.

Test Plan:
- Reset with WARMUP=0, then seed_load with seed_in = {32'h2, 32'h8, 32'h10}, then en high for 2 cycles -> out_32 = 32'h00202080 then 32'h02002C80, each with a one-cycle valid; busy = 0 throughout.
- Same as above with SEED1 = 32'h2, seed_in = {32'h1, 32'h8, 32'h10} -> s1 is sanitised to SEED1; the same two outputs 32'h00202080, 32'h02002C80.
- WARMUP=2, load {2, 8, 16}:
  - busy = 1 for exactly 2 cycles, en ignored meanwhile.
  - First valid sample after RUN is the 3rd step of the sequence, not 32'h00202080 or 32'h02002C80.
- RUN with en pattern 1,0,0,1 -> two valid pulses; out_32 holds its value across the en = 0 cycles; the second sample is the next sequence value (no step skipped).
- seed_load and en asserted in the same cycle during RUN -> no valid, out_32 = 0, state = loaded seed; the next en produces the first sample of the new seed.
- Assert reset asynchronously (between edges) mid-RUN -> out_32 = 0 and valid = 0 immediately; after release the sequence restarts from SEED1/2/3 with identical outputs across two runs.
